fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_next_reg.sv | 47 ++++
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared state encoding and default parameter values for the instruction fetch unit.
package fetch_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_PC_STEP  = 4;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_reg.sv
// Program counter: sequential advance, redirect with forced alignment,
// and a sticky flag recording any misaligned redirect target.
module pc_next_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign
);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    // PC_STEP is a power of two, so STEP-1 selects exactly the offset bits.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0] pc_next;
    logic              misalign_next;

    always_comb begin
        pc_next       = pc;
        misalign_next = misalign;
        if (redirect) begin
            pc_next       = target & ~LOW_MASK;
            misalign_next = misalign | (|(target & LOW_MASK));
        end else if (advance) begin
            pc_next = pc + STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            misalign <= 1'b0;
        end else begin
            pc       <= pc_next;
            misalign <= misalign_next;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding-request fetch FSM with redirect
// handling, a one-entry instruction output register and an acceptance counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP  = DEF_PC_STEP,
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              misalign,
    output logic [CNT_W-1:0]  fetch_cnt
);

    fetch_state_e      state;
    fetch_state_e      state_next;
    logic              drop;
    logic              drop_next;
    logic              inst_valid_next;
    logic              capture;
    logic              accept;
    logic [ADDR_W-1:0] pc;

    pc_next_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .advance  (capture),
        .redirect (redirect_valid),
        .target   (redirect_pc),
        .pc       (pc),
        .misalign (misalign)
    );

    // The address is only meaningful while imem_req is high (ISSUE).
    assign imem_addr = pc;

    always_comb begin
        state_next      = state;
        drop_next       = drop;
        inst_valid_next = inst_valid;
        capture         = 1'b0;
        accept          = 1'b0;
        imem_req        = 1'b0;
        case (state)
            IDLE: begin
                state_next = ISSUE;
                if (redirect_valid) begin
                    inst_valid_next = 1'b0;
                end
            end
            ISSUE: begin
                // The request goes out even when redirected; its reply is dropped.
                imem_req   = 1'b1;
                state_next = WAIT;
                if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    if (imem_rvalid) begin
                        drop_next  = 1'b0;
                        state_next = ISSUE;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = ISSUE;
                    end else begin
                        capture         = 1'b1;
                        inst_valid_next = 1'b1;
                        state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    inst_valid_next = 1'b0;
                    state_next      = ISSUE;
                end else if (inst_ready) begin
                    accept          = 1'b1;
                    inst_valid_next = 1'b0;
                    state_next      = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            inst_valid <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            state      <= state_next;
            drop       <= drop_next;
            inst_valid <= inst_valid_next;
            if (accept) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst    <= '0;
            inst_pc <= '0;
        end else if (capture) begin
            inst    <= imem_rdata;
            inst_pc <= pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: scripted cycle table, reset corner case,
// and randomized traffic against a transaction-level reference model.
module tb_fetch_unit;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          CNT_W    = 16;
    localparam int          PC_STEP  = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              misalign;
    logic [CNT_W-1:0]  fetch_cnt;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign       (misalign),
        .fetch_cnt      (fetch_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_mis;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    function automatic vec_t mk(input int redir, input int rpc, input int rv, input int raddr,
                                input int rdy, input int e_req, input int e_addr, input int e_valid,
                                input int e_pc, input int e_mis, input int e_cnt);
        vec_t v;
        v.redir   = redir[0];
        v.rpc     = 32'(rpc);
        v.rvalid  = rv[0];
        v.rdata   = mem_word(32'(raddr));
        v.ready   = rdy[0];
        v.e_req   = e_req[0];
        v.e_addr  = 32'(e_addr);
        v.e_valid = e_valid[0];
        v.e_pc    = 32'(e_pc);
        v.e_mis   = e_mis[0];
        v.e_cnt   = 16'(e_cnt);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
    endtask

    // Watchdog: every phase is bounded, this only catches a stuck simulator.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_pc;
        logic [15:0] acc;
        logic        mis_m;
        logic        pend;
        int          cd;
        logic [31:0] paddr;
        int          gap;

        idle_inputs();

        // Scripted cycle table: row inputs apply to one cycle, expectations are post-edge.
        tbl.push_back(mk(0, 0,     0, 0,     0, 1, 0,     0, 0,     0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 0));
        tbl.push_back(mk(0, 0,     1, 0,     0, 0, 0,     1, 0,     0, 0));
        tbl.push_back(mk(0, 0,     0, 0,     1, 1, 4,     0, 0,     0, 1));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 1));
        tbl.push_back(mk(0, 0,     1, 4,     0, 0, 0,     1, 4,     0, 1));
        tbl.push_back(mk(0, 0,     0, 0,     1, 1, 8,     0, 0,     0, 2));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 2));
        tbl.push_back(mk(0, 0,     1, 8,     0, 0, 0,     1, 8,     0, 2));
        tbl.push_back(mk(0, 0,     0, 0,     1, 1, 12,    0, 0,     0, 3));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 3));
        tbl.push_back(mk(0, 0,     1, 12,    0, 0, 0,     1, 12,    0, 3));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 0, 0,     0, 0, 0,     1, 12,    0, 3));
        tbl.push_back(mk(0, 0,     0, 0,     1, 1, 16,    0, 0,     0, 4));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 4));
        tbl.push_back(mk(1, 'h100, 0, 0,     0, 0, 0,     0, 0,     0, 4));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 4));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 4));
        tbl.push_back(mk(0, 0,     1, 16,    0, 1, 'h100, 0, 0,     0, 4));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     0, 4));
        tbl.push_back(mk(0, 0,     1, 'h100, 0, 0, 0,     1, 'h100, 0, 4));
        tbl.push_back(mk(0, 0,     0, 0,     1, 1, 'h104, 0, 0,     0, 5));
        tbl.push_back(mk(1, 'h203, 0, 0,     0, 0, 0,     0, 0,     1, 5));
        tbl.push_back(mk(0, 0,     1, 'h104, 0, 1, 'h200, 0, 0,     1, 5));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     1, 5));
        tbl.push_back(mk(1, 'h300, 1, 'h200, 0, 1, 'h300, 0, 0,     1, 5));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     1, 5));
        tbl.push_back(mk(0, 0,     1, 'h300, 0, 0, 0,     1, 'h300, 1, 5));
        tbl.push_back(mk(1, 'h40,  0, 0,     1, 1, 'h40,  0, 0,     1, 5));
        tbl.push_back(mk(0, 0,     0, 0,     0, 0, 0,     0, 0,     1, 5));
        tbl.push_back(mk(0, 0,     1, 'h40,  0, 0, 0,     1, 'h40,  1, 5));
        tbl.push_back(mk(0, 0,     0, 0,     1, 1, 'h44,  0, 0,     1, 6));

        // Reset values while rst is held low.
        #3 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",       32'(imem_req),   0);
        check("rst_valid",     32'(inst_valid), 0);
        check("rst_inst",      inst,            0);
        check("rst_inst_pc",   inst_pc,         0);
        check("rst_misalign",  32'(misalign),   0);
        check("rst_fetch_cnt", 32'(fetch_cnt),  0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            redirect_valid = tbl[i].redir;
            redirect_pc    = tbl[i].rpc;
            imem_rvalid    = tbl[i].rvalid;
            imem_rdata     = tbl[i].rdata;
            inst_ready     = tbl[i].ready;
            step();
            check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req)
                check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d_inst_pc", i), inst_pc, tbl[i].e_pc);
                check($sformatf("vec%0d_inst", i), inst, mem_word(tbl[i].e_pc));
            end
            check($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(tbl[i].e_mis));
            check($sformatf("vec%0d_cnt", i), 32'(fetch_cnt), 32'(tbl[i].e_cnt));
        end
        idle_inputs();

        // Reset mid-WAIT, then a stale response right after release.
        step();
        #2 rst = 1'b0;
        #1;
        check("async_misalign", 32'(misalign),  0);
        check("async_cnt",      32'(fetch_cnt), 0);
        check("async_inst_pc",  inst_pc,        0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(32'h44);
        step();
        imem_rvalid = 1'b0;
        check("stale_req",   32'(imem_req),   1);
        check("stale_addr",  imem_addr,       RESET_PC);
        check("stale_valid", 32'(inst_valid), 0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(RESET_PC);
        step();
        imem_rvalid = 1'b0;
        check("post_rst_valid",   32'(inst_valid), 1);
        check("post_rst_inst_pc", inst_pc,         RESET_PC);
        check("post_rst_inst",    inst,            mem_word(RESET_PC));
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check("post_rst_cnt",  32'(fetch_cnt), 1);
        check("post_rst_addr", imem_addr,      RESET_PC + 32'(PC_STEP));

        // Randomized traffic against a transaction-level model.
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        exp_pc = RESET_PC;
        acc    = '0;
        mis_m  = 1'b0;
        pend   = 1'b0;
        cd     = 0;
        paddr  = '0;
        gap    = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (imem_req) begin
                check("rnd_addr", imem_addr, exp_pc);
                gap = 0;
            end
            if (inst_valid) begin
                check("rnd_inst_pc", inst_pc, exp_pc);
                check("rnd_inst", inst, mem_word(exp_pc));
                gap = 0;
            end
            if (!imem_req && !inst_valid)
                gap++;
            if (gap > 20) begin
                check("rnd_progress", 32'(gap), 0);
                gap = 0;
            end
            check("rnd_cnt", 32'(fetch_cnt), 32'(acc));
            check("rnd_misalign", 32'(misalign), 32'(mis_m));

            imem_rvalid = 1'b0;
            if (pend) begin
                if (cd <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (imem_req) begin
                pend  = 1'b1;
                cd    = int'($urandom_range(1, 4));
                paddr = imem_addr;
            end
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 99) < 7);
            redirect_pc    = 32'($urandom_range(0, 1023));

            if (redirect_valid) begin
                exp_pc = redirect_pc & ~32'(PC_STEP - 1);
                if ((redirect_pc & 32'(PC_STEP - 1)) != 0)
                    mis_m = 1'b1;
            end else if (inst_valid && inst_ready) begin
                exp_pc = exp_pc + 32'(PC_STEP);
                acc    = acc + 16'd1;
            end
            step();
        end
        idle_inputs();
        check("rnd_some_accepted", 32'(acc != 0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
